// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg: shared widths and grant encoding for the frame-buffer arbiter.
package vga_fb_pkg;

  localparam int FB_ADDR_W = 19;  // 640x480 = 307200 words
  localparam int FB_DATA_W = 16;  // one pixel word
  localparam int STAT_W    = 16;  // width of the optional statistics counters

  // Bit 1 set means "a write owns the RAM this cycle", so the registered
  // grant state drives mem_wren straight from a flop.
  typedef enum logic [1:0] {
    GNT_NONE     = 2'd0,
    GNT_DISP     = 2'd1,
    GNT_WR       = 2'd2,
    GNT_FORCE_WR = 2'd3
  } grant_e;

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// vga_fb_arbiter_if: display read port and writer port of the frame-buffer
// arbiter. master = requesters (scanout + draw), slave = the arbiter.
interface vga_fb_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 16
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_ready;
  logic              disp_rvalid;
  logic [DATA_W-1:0] disp_rdata;

  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  modport master (
    output disp_req, disp_addr, wr_valid, wr_addr, wr_data,
    input  disp_ready, disp_rvalid, disp_rdata, wr_ready
  );

  modport slave (
    input  disp_req, disp_addr, wr_valid, wr_addr, wr_data,
    output disp_ready, disp_rvalid, disp_rdata, wr_ready
  );
endinterface

// File: rtl/fb_rd_tag_pipe.sv
// fb_rd_tag_pipe: valid-only shift register that marks when a display read
// accepted DEPTH cycles earlier has its data on mem_q.
module fb_rd_tag_pipe #(
  parameter int DEPTH = 3  // RAM_LAT + 1, so always >= 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic accept,
  output logic rvalid
);

  logic [DEPTH-1:0] vld_sr;

  // Shift one accept tag per cycle; reset drops every in-flight read.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) vld_sr <= '0;
    else          vld_sr <= {vld_sr[DEPTH-2:0], accept};
  end

  assign rvalid = vld_sr[DEPTH-1];

endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port frame-buffer RAM between the VGA
// scanout (reads) and the draw path (writes). Display has priority but the
// writer is forced in after MAX_DISP_RUN consecutive display grants.
// Optional statistics counters: define VGA_FB_ARB_STATS_EN.
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int ADDR_W       = FB_ADDR_W,
  parameter int DATA_W       = FB_DATA_W,
  parameter int RAM_LAT      = 2,  // 1..4
  parameter int MAX_DISP_RUN = 8   // >= 1
) (
  input  logic              clock,
  input  logic              reset_n,
  vga_fb_arbiter_if.slave   bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
`ifdef VGA_FB_ARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] stat_wr_stall,
  output logic [STAT_W-1:0] stat_forced
`endif
);

  localparam int              CNT_W   = $clog2(MAX_DISP_RUN + 1);
  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(MAX_DISP_RUN);

  grant_e           gnt_q, gnt_d;
  logic [CNT_W-1:0] starve_cnt, starve_d;
  logic             disp_win, wr_win;

  // Arbitration and next grant / starvation count from the live requests.
  // NOTE: every output of this block gets a default first, so no latches.
  always_comb begin
    gnt_d    = GNT_NONE;
    starve_d = starve_cnt;
    disp_win = bus.disp_req && (!bus.wr_valid || (starve_cnt < RUN_MAX));
    wr_win   = bus.wr_valid && !disp_win;

    if (disp_win)    gnt_d = GNT_DISP;
    else if (wr_win) gnt_d = bus.disp_req ? GNT_FORCE_WR : GNT_WR;

    if (!bus.wr_valid || wr_win)              starve_d = '0;
    else if (disp_win && starve_cnt < RUN_MAX) starve_d = starve_cnt + 1'b1;
  end

  assign bus.disp_ready = disp_win;
  assign bus.wr_ready   = wr_win;

  // Grant state and starvation counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gnt_q      <= GNT_NONE;
      starve_cnt <= '0;
    end else begin
      gnt_q      <= gnt_d;
      starve_cnt <= starve_d;
    end
  end

  // Write enable is the "write" bit of the registered grant state.
  assign mem_wren = gnt_q[1];

  // Registered RAM address/data; both hold when nobody is granted.
  // NOTE: these are plain datapath registers, not a memory array, so they
  // get a defined reset value for a clean first RAM cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr <= '0;
      mem_data <= '0;
    end else if (disp_win) begin
      mem_addr <= bus.disp_addr;
    end else if (wr_win) begin
      mem_addr <= bus.wr_addr;
      mem_data <= bus.wr_data;
    end
  end

  fb_rd_tag_pipe #(.DEPTH(RAM_LAT + 1)) u_rd_tag_pipe (
    .clock   (clock),
    .reset_n (reset_n),
    .accept  (disp_win),
    .rvalid  (bus.disp_rvalid)
  );

  // Read data passes straight through; disp_rvalid qualifies it.
  assign bus.disp_rdata = mem_q;

`ifdef VGA_FB_ARB_STATS_EN
  logic [STAT_W-1:0] stall_q, forced_q;

  // Saturating stall / forced-slot counters; clear beats increment.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_q  <= '0;
      forced_q <= '0;
    end else if (stat_clr) begin
      stall_q  <= '0;
      forced_q <= '0;
    end else begin
      if (bus.wr_valid && !wr_win && stall_q != '1) stall_q  <= stall_q + 1'b1;
      if (gnt_d == GNT_FORCE_WR && forced_q != '1)  forced_q <= forced_q + 1'b1;
    end
  end

  assign stat_wr_stall = stall_q;
  assign stat_forced   = forced_q;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: directed tests with literal expectations plus a
// per-cycle reference model of the arbitration and read-return rules.
`timescale 1ns/1ps
module tb_vga_fb_arbiter;
  import vga_fb_pkg::*;

  localparam int ADDR_W  = 19;
  localparam int DATA_W  = 16;
  localparam int RAM_LAT = 2;
  localparam int MAXRUN  = 8;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;
`ifdef VGA_FB_ARB_STATS_EN
  logic              stat_clr;
  logic [15:0]       stat_wr_stall, stat_forced;
`endif

  vga_fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vga_fb_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_LAT(RAM_LAT), .MAX_DISP_RUN(MAXRUN)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .bus      (bus),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_wren (mem_wren),
    .mem_q    (mem_q)
`ifdef VGA_FB_ARB_STATS_EN
    ,
    .stat_clr      (stat_clr),
    .stat_wr_stall (stat_wr_stall),
    .stat_forced   (stat_forced)
`endif
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- RAM model: latency RAM_LAT=2 from mem_addr ----------
  logic [DATA_W-1:0] ram [1024];
  logic [ADDR_W-1:0] rd_a1;
  logic [DATA_W-1:0] rd_q = '0;

  always @(posedge clock) begin
    rd_a1 <= mem_addr;
    rd_q  <= ram[rd_a1[9:0]];
    if (mem_wren) ram[mem_addr[9:0]] <= mem_data;
  end
  assign mem_q = rd_q;

  // ---------------- reference model + compare process -------------------
  typedef struct {
    int                due;
    logic [ADDR_W-1:0] addr;
  } rd_t;

  rd_t               rdq[$];
  int                cyc   = 0;
  int                m_run = 0;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  logic              m_wren;
  logic              e_dr, e_wr, e_rv;

  always @(negedge clock) begin
    if (!reset_n) begin
      check("rst_mem_wren", mem_wren, 1'b0);
      check("rst_rvalid", bus.disp_rvalid, 1'b0);
      m_addr = '0; m_data = '0; m_wren = 1'b0; m_run = 0;
      rdq.delete();
    end else begin
      e_dr = bus.disp_req && (!bus.wr_valid || m_run < MAXRUN);
      e_wr = bus.wr_valid && !e_dr;
      check("m_disp_ready", bus.disp_ready, e_dr);
      check("m_wr_ready", bus.wr_ready, e_wr);
      check("m_mem_addr", mem_addr, m_addr);
      check("m_mem_data", mem_data, m_data);
      check("m_mem_wren", mem_wren, m_wren);
      e_rv = (rdq.size() > 0) && (rdq[0].due == cyc);
      check("m_rvalid", bus.disp_rvalid, e_rv);
      if (e_rv) begin
        check("m_rdata", bus.disp_rdata, ram[rdq[0].addr[9:0]]);
        void'(rdq.pop_front());
      end
      // next-cycle expectations
      m_wren = e_wr;
      if (e_dr) begin
        m_addr = bus.disp_addr;
        rdq.push_back('{due: cyc + RAM_LAT + 1, addr: bus.disp_addr});
      end else if (e_wr) begin
        m_addr = bus.wr_addr;
        m_data = bus.wr_data;
      end
      if (!bus.wr_valid || e_wr) m_run = 0;
      else if (e_dr && m_run < MAXRUN) m_run++;
    end
    cyc++;
  end

  // ---------------- stimulus helpers -----------------------------------
  task automatic drive(input logic dr, input logic [ADDR_W-1:0] da, input logic wv,
                       input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd);
    bus.disp_req  = dr;
    bus.disp_addr = da;
    bus.wr_valid  = wv;
    bus.wr_addr   = wa;
    bus.wr_data   = wd;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, '0, 1'b0, '0, '0);
    repeat (n) tick();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = DATA_W'(32'h1000 + i * 32'h111);
    reset_n = 1'b0;
`ifdef VGA_FB_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    drive(1'b0, '0, 1'b0, '0, '0);
    repeat (3) tick();

    // reset values
    check("reset_mem_addr", mem_addr, '0);
    check("reset_mem_data", mem_data, '0);
    check("reset_mem_wren", mem_wren, 1'b0);
    check("reset_rvalid", bus.disp_rvalid, 1'b0);
    reset_n = 1'b1;
    idle(2);

    // display-only: 10 reads of addr 0..9, data returns 3 cycles later
    for (int k = 0; k < 16; k++) begin
      if (k < 10) drive(1'b1, ADDR_W'(k), 1'b0, '0, '0);
      else        drive(1'b0, '0, 1'b0, '0, '0);
      @(negedge clock);
      if (k < 10) check("disp_only_ready", bus.disp_ready, 1'b1);
      check("disp_only_wren", mem_wren, 1'b0);
      check("disp_only_rvalid", bus.disp_rvalid, (k >= 3 && k <= 12));
      if (k >= 3 && k <= 12)
        check("disp_only_rdata", bus.disp_rdata, DATA_W'(32'h1000 + (k - 3) * 32'h111));
      tick();
    end

    // write-only: one write of 16'hABCD to address 5
    drive(1'b0, '0, 1'b1, ADDR_W'(5), 16'hABCD);
    @(negedge clock);
    check("wr_only_ready", bus.wr_ready, 1'b1);
    check("wr_only_disp_ready", bus.disp_ready, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, '0, '0);
    @(negedge clock);
    check("wr_only_addr", mem_addr, 5);
    check("wr_only_data", mem_data, 16'hABCD);
    check("wr_only_wren", mem_wren, 1'b1);
    tick();
    @(negedge clock);
    check("wr_only_wren_drop", mem_wren, 1'b0);
    check("wr_only_addr_hold", mem_addr, 5);
    idle(4);

    // contention: 8 display grants then one forced write, repeating
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, ADDR_W'(100 + k), 1'b1, ADDR_W'(200 + k), DATA_W'(32'h5000 + k));
      @(negedge clock);
      check("cont_wr_ready", bus.wr_ready, (k == 8 || k == 17));
      check("cont_disp_ready", bus.disp_ready, !(k == 8 || k == 17));
      if (k == 8) check("cont_starve_max", dut.starve_cnt, MAXRUN);
      if (k == 9) begin
        check("cont_force_state", dut.gnt_q, GNT_FORCE_WR);
        check("cont_starve_clr", dut.starve_cnt, 0);
      end
      tick();
    end
    idle(6);

    // writer arrives late: rises at cycle 3, granted at cycle 11
    for (int k = 0; k < 15; k++) begin
      drive(1'b1, ADDR_W'(300 + k), (k >= 3), ADDR_W'(400 + k), DATA_W'(32'h6000 + k));
      @(negedge clock);
      check("late_wr_ready", bus.wr_ready, (k == 11));
      if (k == 12) check("late_starve_after", dut.starve_cnt, 0);
      tick();
    end
    idle(6);

    // reset one cycle after three display accepts: reads are dropped
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, ADDR_W'(50 + k), 1'b0, '0, '0);
      tick();
    end
    drive(1'b0, '0, 1'b0, '0, '0);
    reset_n = 1'b0;
    #1;
    check("midrst_wren", mem_wren, 1'b0);
    check("midrst_state", dut.gnt_q, GNT_NONE);
    check("midrst_rvalid", bus.disp_rvalid, 1'b0);
    repeat (2) tick();
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      check("postrst_rvalid", bus.disp_rvalid, 1'b0);
      tick();
    end

`ifdef VGA_FB_ARB_STATS_EN
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    for (int k = 0; k < 18; k++) begin
      drive(1'b1, ADDR_W'(500 + k), 1'b1, ADDR_W'(600 + k), DATA_W'(k));
      tick();
    end
    drive(1'b0, '0, 1'b0, '0, '0);
    @(negedge clock);
    check("stat_forced", stat_forced, 2);
    check("stat_wr_stall", stat_wr_stall, 16);
    tick();
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    @(negedge clock);
    check("stat_clr_forced", stat_forced, 0);
    check("stat_clr_stall", stat_wr_stall, 0);
`endif

    idle(6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
